// File: rtl/my_nios_irq_ctrl.sv
// Purpose: aggregates NUM_SRC level/edge interrupt sources into one registered CPU irq plus a lowest-index vector.
// Latency: source to pending 1 edge, pending to irq/irq_vector 1 more edge (+2 edges with MY_NIOS_IRQ_SYNC_EN); reads 1 cycle.
// Backpressure: none; the Avalon slave never stalls and every access completes in one cycle.
// Optional feature macro: MY_NIOS_IRQ_SYNC_EN adds a two-flop input synchronizer on every irq_in bit.
module my_nios_irq_ctrl #(
   parameter int NUM_SRC = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               chipselect,
   input  logic [2:0]         address,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq,
   output logic [3:0]         irq_vector
);

   // Register word addresses
   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_MODE    = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
   localparam logic [2:0] ADDR_VECTOR  = 3'd4;
   localparam logic [2:0] ADDR_FORCE   = 3'd5;

   // Bits at and above NUM_SRC are held at zero in every register
   localparam logic [15:0] SRC_MSK = (NUM_SRC >= 16) ? 16'hFFFF
                                   : 16'((32'd1 << NUM_SRC) - 32'd1);

   logic [NUM_SRC-1:0] smp_raw;
   logic [15:0]        smp;
   logic [15:0]        prev_q;
   logic [15:0]        pend_q;
   logic [15:0]        mask_q;
   logic [15:0]        mode_q;
   logic [15:0]        wr_bits;
   logic [15:0]        w1c;
   logic [15:0]        frc;
   logic [15:0]        rise;
   logic [15:0]        edge_nxt;
   logic [15:0]        pend_nxt;
   logic [15:0]        active;
   logic [3:0]         vec_nxt;
   logic               wr_en;

`ifdef MY_NIOS_IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync_q1;
   logic [NUM_SRC-1:0] sync_q2;

   // Two-flop synchronizer for sources that are asynchronous to clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_in;
         sync_q2 <= sync_q1;
      end
   end

   assign smp_raw = sync_q2;
`else
   assign smp_raw = irq_in;
`endif

   assign smp     = 16'(smp_raw);
   assign wr_en   = chipselect & ~write_n;
   assign wr_bits = writedata & SRC_MSK;
   assign w1c     = (wr_en && address == ADDR_PENDING) ? wr_bits : 16'h0000;
   assign frc     = (wr_en && address == ADDR_FORCE)   ? wr_bits : 16'h0000;

   // Edge sources: a rising edge or a force bit sets pending and beats a same-cycle W1C.
   // Level sources simply mirror the sampled input; W1C/FORCE do not touch them.
   assign rise     = smp & ~prev_q;
   assign edge_nxt = rise | frc | (pend_q & ~w1c);
   assign pend_nxt = ((mode_q & edge_nxt) | (~mode_q & smp)) & SRC_MSK;
   assign active   = pend_q & mask_q;

   // Lowest-numbered active source wins; scanning downwards leaves the lowest index last
   always_comb begin
      vec_nxt = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (active[i]) vec_nxt = 4'(i);
      end
   end

   // Source capture, pending update and control register writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
         pend_q <= '0;
         mask_q <= '0;
         mode_q <= '0;
      end else begin
         prev_q <= smp;
         pend_q <= pend_nxt;
         if (wr_en && address == ADDR_MASK) mask_q <= wr_bits;
         if (wr_en && address == ADDR_MODE) mode_q <= wr_bits;
      end
   end

   // Combined interrupt and vector are registered from the current pending/mask state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq        <= 1'b0;
         irq_vector <= 4'd0;
      end else begin
         irq        <= |active;
         irq_vector <= vec_nxt;
      end
   end

   // Read data is refreshed every cycle from address, independent of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         case (address)
            ADDR_PENDING: readdata <= pend_q;
            ADDR_MASK:    readdata <= mask_q;
            ADDR_MODE:    readdata <= mode_q;
            ADDR_ACTIVE:  readdata <= active;
            ADDR_VECTOR:  readdata <= {irq, 11'd0, irq_vector};
            default:      readdata <= 16'h0000;
         endcase
      end
   end

endmodule
